mc_data_sync: RTL and testbench

Multi-channel, parametrised successor to the single-bus data synchroniser. It carries NUM_CH independent BUS_WIDTH-bit buses from foreign clock domains into the CLK domain. Each channel uses the multi-flop enable / held-data scheme and detects either enable pulses or enable toggles. Each channel buffers one pending word and flags overruns, and a round-robin arbiter merges all channels onto one valid/ready output stream. It sits at the CLK-domain boundary, in front of the register file / system controller.

---
 rtl/mc_data_sync.sv | 158 +++++++++++++++
 tb/tb_mc_data_sync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_data_sync.sv
// rtl/mc_data_sync.sv - multi-channel enable/held-data synchroniser with round-robin output stream
//
// Purpose:
//   Carries NUM_CH independent BUS_WIDTH-bit buses from foreign clock domains
//   into the CLK domain. Each channel synchronises its bus_enable through a
//   NUM_STAGES flop chain, detects either a rising edge (level mode) or any
//   edge (toggle mode), captures its data slice into a one-word holding
//   register and raises a pending flag. A round-robin arbiter merges the
//   pending words onto a single valid/ready output stream.
//
// Ports:
//   CLK          destination clock, the only clock
//   RST          synchronous active-high reset
//   unsync_bus   NUM_CH*BUS_WIDTH data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   bus_enable   per-channel enable (level mode) or toggle (toggle mode)
//   sync_bus     output data word
//   sync_ch      source channel of sync_bus
//   sync_valid   output word valid
//   sync_ready   consumer accepts the output word
//   overrun      sticky per-channel overrun flags
//   ovr_clr      per-channel overrun clear
module mc_data_sync #(
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = $clog2(NUM_CH),
  parameter bit TOGGLE_MODE = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
  input  logic [NUM_CH-1:0]           bus_enable,
  output logic [BUS_WIDTH-1:0]        sync_bus,
  output logic [CH_W-1:0]             sync_ch,
  output logic                        sync_valid,
  input  logic                        sync_ready,
  output logic [NUM_CH-1:0]           overrun,
  input  logic [NUM_CH-1:0]           ovr_clr
);

  logic [NUM_CH-1:0]    pend_vec;
  logic [NUM_CH-1:0]    ovr_vec;
  logic [BUS_WIDTH-1:0] hold_arr [NUM_CH];

  logic [BUS_WIDTH-1:0] sync_bus_q;
  logic [CH_W-1:0]      sync_ch_q;
  logic                 sync_valid_q;
  logic [CH_W-1:0]      rr_ptr_q;
  logic [CH_W-1:0]      rr_ptr_d;

  logic                 loadable;
  logic                 found;
  logic                 gnt_vld;
  logic [CH_W-1:0]      gnt_idx;
  int                   idx;

  // Output register may take a new word when empty or when its current word
  // is being accepted this cycle.
  assign loadable = !sync_valid_q || sync_ready;
  assign gnt_vld  = loadable && found;

  // First pending channel at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      if (!found && pend_vec[CH_W'(idx)]) begin
        found   = 1'b1;
        gnt_idx = CH_W'(idx);
      end
    end
  end

  assign rr_ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NUM_STAGES-1:0] sync_q;
    logic                  prev_q;
    logic [BUS_WIDTH-1:0]  hold_q;
    logic                  pend_q;
    logic                  pend_d;
    logic                  ovr_q;
    logic                  ovr_d;
    logic                  evt;
    logic                  gnt_here;

    assign evt = TOGGLE_MODE ? (sync_q[NUM_STAGES-1] ^ prev_q)
                             : (sync_q[NUM_STAGES-1] & ~prev_q);
    assign gnt_here = gnt_vld && (gnt_idx == CH_W'(c));

    // A new event beats a same-cycle grant: the granted word leaves, the new
    // word stays pending. An event only counts as overrun if the pending word
    // is not leaving this cycle; a set beats a same-cycle clear.
    always_comb begin
      pend_d = pend_q;
      ovr_d  = ovr_q;
      if (evt) begin
        pend_d = 1'b1;
      end else if (gnt_here) begin
        pend_d = 1'b0;
      end
      if (evt && pend_q && !gnt_here) begin
        ovr_d = 1'b1;
      end else if (ovr_clr[c]) begin
        ovr_d = 1'b0;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) begin
        sync_q <= '0;
        prev_q <= 1'b0;
        hold_q <= '0;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[NUM_STAGES-2:0], bus_enable[c]};
        prev_q <= sync_q[NUM_STAGES-1];
        if (evt) begin
          hold_q <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
        end
        pend_q <= pend_d;
        ovr_q  <= ovr_d;
      end
    end

    assign pend_vec[c] = pend_q;
    assign ovr_vec[c]  = ovr_q;
    assign hold_arr[c] = hold_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_bus_q   <= '0;
      sync_ch_q    <= '0;
      sync_valid_q <= 1'b0;
      rr_ptr_q     <= '0;
    end else if (gnt_vld) begin
      sync_bus_q   <= hold_arr[gnt_idx];
      sync_ch_q    <= gnt_idx;
      sync_valid_q <= 1'b1;
      rr_ptr_q     <= rr_ptr_d;
    end else if (sync_valid_q && sync_ready) begin
      sync_valid_q <= 1'b0;
    end
  end

  assign sync_bus   = sync_bus_q;
  assign sync_ch    = sync_ch_q;
  assign sync_valid = sync_valid_q;
  assign overrun    = ovr_vec;

endmodule

// File: tb/tb_mc_data_sync.sv
// tb/tb_mc_data_sync.sv - directed table-driven bench for mc_data_sync (level and toggle instances)
module tb_mc_data_sync;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST;
  logic [31:0] ubus, ubus_t;
  logic [3:0]  en, en_t, clr, clr_t;
  logic        ready, ready_t;
  logic [7:0]  sbus, sbus_t;
  logic [1:0]  sch, sch_t;
  logic        svalid, svalid_t;
  logic [3:0]  ovr, ovr_t;

  int n_chk  = 0;
  int n_fail = 0;

  mc_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(1'b0)) dut (
    .CLK(CLK), .RST(RST), .unsync_bus(ubus), .bus_enable(en),
    .sync_bus(sbus), .sync_ch(sch), .sync_valid(svalid), .sync_ready(ready),
    .overrun(ovr), .ovr_clr(clr)
  );

  mc_data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8), .NUM_CH(4), .TOGGLE_MODE(1'b1)) dut_t (
    .CLK(CLK), .RST(RST), .unsync_bus(ubus_t), .bus_enable(en_t),
    .sync_bus(sbus_t), .sync_ch(sch_t), .sync_valid(svalid_t), .sync_ready(ready_t),
    .overrun(ovr_t), .ovr_clr(clr_t)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  en;
    logic [31:0] data;
    logic        rdy;
    logic        v;
    logic [7:0]  b;
    logic [1:0]  ch;
    logic [3:0]  o;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] e, input logic [31:0] d,
                     input logic r, input logic v, input logic [7:0] b,
                     input logic [1:0] ch, input logic [3:0] o);
    vec_t x;
    x.rst = rst; x.en = e; x.data = d; x.rdy = r;
    x.v = v; x.b = b; x.ch = ch; x.o = o;
    vq.push_back(x);
  endtask

  // Pulse the masked enables on the level instance; returns right after the
  // edge that captures the word. clr and ready are applied for that edge.
  task automatic fire(input logic [3:0] m, input logic [31:0] d,
                      input logic [3:0] c, input logic r_last);
    ubus = d;
    en   = en | m;
    step();
    step();
    en    = en & ~m;
    clr   = c;
    ready = r_last;
    step();
    clr = 4'h0;
  endtask

  initial begin
    RST = 1'b1; ubus = '0; ubus_t = '0; en = '0; en_t = '0;
    clr = '0; clr_t = '0; ready = 1'b1; ready_t = 1'b1;

    // rst en data rdy | valid bus ch ovr
    add(1, 4'h0, 32'h0,        1, 0, 8'h00, 0, 4'h0);  // reset state
    add(0, 4'h0, 32'h0,        1, 0, 8'h00, 0, 4'h0);
    add(0, 4'h2, 32'h0000A500, 1, 0, 8'h00, 0, 4'h0);  // E0
    add(0, 4'h2, 32'h0000A500, 1, 0, 8'h00, 0, 4'h0);
    add(0, 4'h0, 32'h0000A500, 1, 0, 8'h00, 0, 4'h0);
    add(0, 4'h0, 32'h0000A500, 1, 1, 8'hA5, 1, 4'h0);  // E0+3
    add(0, 4'h0, 32'h0000A500, 1, 0, 8'hA5, 1, 4'h0);
    add(0, 4'h0, 32'h0000A500, 1, 0, 8'hA5, 1, 4'h0);
    add(1, 4'h0, 32'h0,        1, 0, 8'h00, 0, 4'h0);  // reset -> rr_ptr=0
    add(0, 4'h0, 32'h0,        1, 0, 8'h00, 0, 4'h0);
    add(0, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 4'h0);
    add(0, 4'hF, 32'h13121110, 1, 0, 8'h00, 0, 4'h0);
    add(0, 4'h0, 32'h13121110, 1, 0, 8'h00, 0, 4'h0);
    add(0, 4'h0, 32'h13121110, 1, 1, 8'h10, 0, 4'h0);
    add(0, 4'h0, 32'h13121110, 1, 1, 8'h11, 1, 4'h0);
    add(0, 4'h0, 32'h13121110, 1, 1, 8'h12, 2, 4'h0);
    add(0, 4'h0, 32'h13121110, 1, 1, 8'h13, 3, 4'h0);
    add(0, 4'h0, 32'h13121110, 1, 0, 8'h13, 3, 4'h0);
    add(0, 4'hF, 32'h23222120, 1, 0, 8'h13, 3, 4'h0);
    add(0, 4'hF, 32'h23222120, 1, 0, 8'h13, 3, 4'h0);
    add(0, 4'h0, 32'h23222120, 1, 0, 8'h13, 3, 4'h0);
    add(0, 4'h0, 32'h23222120, 1, 1, 8'h20, 0, 4'h0);
    add(0, 4'h0, 32'h23222120, 1, 1, 8'h21, 1, 4'h0);
    add(0, 4'h0, 32'h23222120, 1, 1, 8'h22, 2, 4'h0);
    add(0, 4'h0, 32'h23222120, 1, 1, 8'h23, 3, 4'h0);
    add(0, 4'h0, 32'h23222120, 1, 0, 8'h23, 3, 4'h0);

    foreach (vq[i]) begin
      RST = vq[i].rst; en = vq[i].en; ubus = vq[i].data; ready = vq[i].rdy;
      step();
      chk($sformatf("row%0d valid", i), svalid, vq[i].v);
      chk($sformatf("row%0d bus", i),   sbus,   vq[i].b);
      chk($sformatf("row%0d ch", i),    sch,    vq[i].ch);
      chk($sformatf("row%0d ovr", i),   ovr,    vq[i].o);
    end

    // Toggle instance: 0->1 with 0x11, then 1->0 ten cycles later with 0x22.
    ubus_t = 32'h11; en_t = 4'h1;
    step(); step(); step();
    chk("tog first early", svalid_t, 1'b0);
    step();
    chk("tog first valid", svalid_t, 1'b1);
    chk("tog first bus",   sbus_t,   8'h11);
    chk("tog first ch",    sch_t,    2'd0);
    step();
    chk("tog first drop",  svalid_t, 1'b0);
    for (int i = 0; i < 5; i++) step();
    ubus_t = 32'h22; en_t = 4'h0;
    step(); step(); step();
    chk("tog second early", svalid_t, 1'b0);
    step();
    chk("tog second valid", svalid_t, 1'b1);
    chk("tog second bus",   sbus_t,   8'h22);
    chk("tog second ch",    sch_t,    2'd0);
    step();
    chk("tog second drop", svalid_t, 1'b0);
    step();
    chk("tog idle", svalid_t, 1'b0);
    chk("tog ovr",  ovr_t,    4'h0);

    // Backpressure and overrun on ch2.
    ready = 1'b0;
    fire(4'h1, 32'h01, 4'h0, 1'b0);
    step();
    chk("bp hold valid", svalid, 1'b1);
    chk("bp hold bus",   sbus,   8'h01);
    fire(4'h4, 32'h00330000, 4'h0, 1'b0);
    step();
    chk("bp no ovr yet", ovr, 4'h0);
    fire(4'h4, 32'h00440000, 4'h0, 1'b0);
    chk("bp ovr set",     ovr,    4'h4);
    chk("bp stable bus",  sbus,   8'h01);
    chk("bp stable ch",   sch,    2'd0);
    chk("bp stable vld",  svalid, 1'b1);
    ready = 1'b1;
    step();
    chk("bp latest bus", sbus,   8'h44);
    chk("bp latest ch",  sch,    2'd2);
    chk("bp latest vld", svalid, 1'b1);
    step();
    chk("bp drained", svalid, 1'b0);
    chk("bp ovr sticky", ovr, 4'h4);
    clr = 4'h4;
    step();
    clr = 4'h0;
    chk("bp ovr clr", ovr, 4'h0);

    // Clear in the same cycle as an overrun set: set wins.
    ready = 1'b0;
    fire(4'h1, 32'h02, 4'h0, 1'b0);
    step();
    fire(4'h4, 32'h00550000, 4'h0, 1'b0);
    step();
    fire(4'h4, 32'h00660000, 4'h4, 1'b0);
    chk("clr vs set ovr", ovr, 4'h4);
    ready = 1'b1;
    step();
    chk("clr vs set bus", sbus, 8'h66);
    step();
    chk("clr vs set drain", svalid, 1'b0);
    clr = 4'h4;
    step();
    clr = 4'h0;
    chk("clr vs set cleared", ovr, 4'h0);

    // Event on ch3 in the cycle ch3 is granted.
    ready = 1'b0;
    fire(4'h1, 32'h03, 4'h0, 1'b0);
    step();
    chk("gnt evt occupy", sbus, 8'h03);
    fire(4'h8, 32'h77000000, 4'h0, 1'b0);
    step();
    fire(4'h8, 32'h88000000, 4'h0, 1'b1);
    chk("gnt evt old bus", sbus,   8'h77);
    chk("gnt evt old ch",  sch,    2'd3);
    chk("gnt evt no ovr",  ovr,    4'h0);
    step();
    chk("gnt evt new bus", sbus,   8'h88);
    chk("gnt evt new ch",  sch,    2'd3);
    chk("gnt evt new vld", svalid, 1'b1);
    step();
    chk("gnt evt drain",   svalid, 1'b0);
    chk("gnt evt ovr end", ovr,    4'h0);

    // Reset with an in-flight word and two pending channels.
    ready = 1'b0;
    fire(4'h1, 32'h04, 4'h0, 1'b0);
    step();
    fire(4'h6, 32'h00BBAA00, 4'h0, 1'b0);
    chk("rst pre valid", svalid, 1'b1);
    chk("rst pre bus",   sbus,   8'h04);
    RST = 1'b1;
    step();
    chk("rst valid", svalid, 1'b0);
    chk("rst bus",   sbus,   8'h00);
    chk("rst ch",    sch,    2'd0);
    chk("rst ovr",   ovr,    4'h0);
    RST = 1'b0; ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("rst stale %0d", i), svalid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
